// File: rtl/ring_freq_meter.sv
// ring_freq_meter: selects one of N_CH asynchronous ring-oscillator taps and
// counts its rising edges over a programmable gate window of clk cycles.
// The saturating result is presented on a valid/ready port.
// Single-shot and continuous (auto re-arm) modes are supported.
module ring_freq_meter #(
  parameter  int N_CH   = 8,
  parameter  int CNT_W  = 16,
  parameter  int GATE_W = 16,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ring_in,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic [CH_W-1:0]   res_ch,
  output logic              res_ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              latch;
  logic [N_CH-1:0]   sync1;
  logic [N_CH-1:0]   sync2;
  logic              hist;
  logic              edge_det;
  logic [CH_W-1:0]   ch_q;
  logic [GATE_W-1:0] gate_q;
  logic [GATE_W-1:0] tmr;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;

  // Rising edge of the selected, synchronised tap.
  assign edge_det = sync2[ch_q] & ~hist;

  // Result outputs come straight from registers.
  assign res_count = cnt;
  assign res_ch    = ch_q;
  assign res_ovf   = ovf;

  // Next-state logic; latch marks a point where ch_sel/gate_len are captured.
  always_comb begin
    state_next = state;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch      = 1'b1;
          state_next = SETTLE;
        end else begin
          state_next = IDLE;
        end
      end
      SETTLE: begin
        if (tmr == '0) begin
          state_next = COUNT;
        end else begin
          state_next = SETTLE;
        end
      end
      COUNT: begin
        if (tmr == '0) begin
          state_next = HOLD;
        end else begin
          state_next = COUNT;
        end
      end
      HOLD: begin
        if (res_ready && continuous) begin
          latch      = 1'b1;
          state_next = SETTLE;
        end else if (res_ready) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register, synchronisers, window timer and saturating edge counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      sync1     <= '0;
      sync2     <= '0;
      hist      <= 1'b0;
      ch_q      <= '0;
      gate_q    <= '0;
      tmr       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != IDLE);
      res_valid <= (state_next == HOLD);
      sync1     <= ring_in;
      sync2     <= sync1;
      // History always follows the current channel, so SETTLE flushes stale edges.
      hist      <= sync2[ch_q];
      if (latch) begin
        ch_q   <= ch_sel;
        gate_q <= (gate_len == '0) ? GATE_W'(1) : gate_len;
        tmr    <= GATE_W'(2);
        cnt    <= '0;
        ovf    <= 1'b0;
      end else begin
        case (state)
          SETTLE: begin
            if (tmr == '0) begin
              tmr <= gate_q - GATE_W'(1);
            end else begin
              tmr <= tmr - GATE_W'(1);
            end
          end
          COUNT: begin
            if (tmr != '0) begin
              tmr <= tmr - GATE_W'(1);
            end
            // An edge arriving at all-ones is the overflow event.
            if (edge_det) begin
              if (&cnt) begin
                ovf <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Directed testbench for ring_freq_meter with a result scoreboard.
module tb_ring_freq_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ring_in;
  logic [2:0]  ch_sel;
  logic [15:0] gate_len;
  logic        start, start_s;
  logic        continuous;
  logic        res_ready, res_ready_s;
  logic        busy, busy_s;
  logic        res_valid, res_valid_s;
  logic [15:0] res_count;
  logic [3:0]  res_count_s;
  logic [2:0]  res_ch, res_ch_s;
  logic        res_ovf, res_ovf_s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int half [8];
  logic lvl [8];

  typedef struct {
    int cnt;
    int tol;
    int ch;
    int ovf;
    int lat;
    int sat;
  } exp_t;
  exp_t sbq[$];

  ring_freq_meter #(.N_CH(8), .CNT_W(16), .GATE_W(16)) u_dut (
    .clk(clk), .rst(rst), .ring_in(ring_in), .ch_sel(ch_sel), .gate_len(gate_len),
    .start(start), .continuous(continuous), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_count(res_count), .res_ch(res_ch), .res_ovf(res_ovf)
  );

  ring_freq_meter #(.N_CH(8), .CNT_W(4), .GATE_W(16)) u_sat (
    .clk(clk), .rst(rst), .ring_in(ring_in), .ch_sel(ch_sel), .gate_len(gate_len),
    .start(start_s), .continuous(1'b0), .busy(busy_s), .res_valid(res_valid_s),
    .res_ready(res_ready_s), .res_count(res_count_s), .res_ch(res_ch_s), .res_ovf(res_ovf_s)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement and ring waveform generation.
  always @(posedge clk) cyc <= cyc + 1;

  // Ring taps: toggle every half[i] cycles, or hold lvl[i] when half[i] is 0.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 8; i++) begin
      if (half[i] == 0) ring_in[i] = lvl[i];
      else              ring_in[i] = ((cyc / half[i]) % 2) == 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic push(input int c, input int tol, input int ch, input int ovf, input int lat, input int sat);
    exp_t e;
    e.cnt = c; e.tol = tol; e.ch = ch; e.ovf = ovf; e.lat = lat; e.sat = sat;
    sbq.push_back(e);
  endtask

  task automatic do_start(input int ch, input int g, input bit sat);
    ch_sel   = 3'(ch);
    gate_len = 16'(g);
    if (sat) start_s = 1'b1;
    else     start   = 1'b1;
    t0 = cyc;
    step(1);
    start   = 1'b0;
    start_s = 1'b0;
  endtask

  // Wait (bounded) for the next result, then pop and compare against the scoreboard.
  task automatic wait_result();
    exp_t e;
    bit   seen;
    int   c, ch, ov;
    e = sbq.pop_front();
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (e.sat != 0) seen = (res_valid_s === 1'b1);
      else            seen = (res_valid === 1'b1);
      if (!seen) step(1);
    end
    chk("result_timeout", 64'(seen), 64'd1);
    if (e.sat != 0) begin
      c = int'(res_count_s); ch = int'(res_ch_s); ov = int'(res_ovf_s);
    end else begin
      c = int'(res_count); ch = int'(res_ch); ov = int'(res_ovf);
    end
    chk("latency", 64'(cyc - t0), 64'(e.lat));
    chk_range("res_count", c, e.cnt - e.tol, e.cnt + e.tol);
    chk("res_ch", 64'(ch), 64'(e.ch));
    chk("res_ovf", 64'(ov), 64'(e.ovf));
  endtask

  initial begin
    int c0, bad, seen_cnt;
    for (int i = 0; i < 8; i++) begin
      half[i] = 0;
      lvl[i]  = 1'b0;
    end
    half[3] = 4;
    half[5] = 2;
    half[1] = 2;
    lvl[7]  = 1'b1;
    ring_in     = '0;
    rst         = 1'b1;
    ch_sel      = '0;
    gate_len    = '0;
    start       = 1'b0;
    start_s     = 1'b0;
    continuous  = 1'b0;
    res_ready   = 1'b0;
    res_ready_s = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_count", 64'(res_count), 64'd0);
    chk("rst_ch", 64'(res_ch), 64'd0);
    chk("rst_ovf", 64'(res_ovf), 64'd0);

    // Single-shot: channel 3, period 8, gate 80
    push(10, 1, 3, 0, 84, 0);
    do_start(3, 80, 1'b0);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_result();
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    chk("busy_after_ack", 64'(busy), 64'd0);
    chk("valid_after_ack", 64'(res_valid), 64'd0);

    // gate_len 0 behaves as 1; static-high channel gives no phantom edge
    push(0, 0, 7, 0, 5, 0);
    do_start(7, 0, 1'b0);
    wait_result();
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;

    // Static-high channel over a longer window
    push(0, 0, 7, 0, 24, 0);
    do_start(7, 20, 1'b0);
    wait_result();
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;

    // start / ch_sel / gate_len during COUNT are ignored
    push(10, 1, 5, 0, 44, 0);
    do_start(5, 40, 1'b0);
    step(10);
    ch_sel   = 3'd3;
    gate_len = 16'd5;
    start    = 1'b1;
    step(3);
    start    = 1'b0;
    wait_result();
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;

    // Reset mid-COUNT discards the measurement
    do_start(3, 80, 1'b0);
    step(30);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(res_valid), 64'd0);
    chk("midrst_count", 64'(res_count), 64'd0);
    chk("midrst_ch", 64'(res_ch), 64'd0);
    chk("midrst_ovf", 64'(res_ovf), 64'd0);
    seen_cnt = 0;
    repeat (150) begin
      step(1);
      if (res_valid !== 1'b0 || busy !== 1'b0) seen_cnt++;
    end
    chk("no_result_after_rst", 64'(seen_cnt), 64'd0);

    // Continuous mode with back-pressure, channel switch at the handshake
    continuous = 1'b1;
    push(5, 1, 3, 0, 44, 0);
    do_start(3, 40, 1'b0);
    wait_result();
    c0  = int'(res_count);
    bad = 0;
    repeat (20) begin
      step(1);
      if (res_valid !== 1'b1 || int'(res_count) != c0 || res_ch !== 3'd3 || res_ovf !== 1'b0) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    ch_sel    = 3'd5;
    res_ready = 1'b1;
    t0        = cyc;
    push(10, 1, 5, 0, 44, 0);
    step(1);
    res_ready  = 1'b0;
    continuous = 1'b0;
    ch_sel     = 3'd3;
    chk("cont_valid_drop", 64'(res_valid), 64'd0);
    chk("cont_busy", 64'(busy), 64'd1);
    wait_result();
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    chk("cont_stop_busy", 64'(busy), 64'd0);

    // Saturation on the 4-bit instance: ~25 edges in 100 cycles
    push(15, 0, 1, 1, 104, 1);
    do_start(1, 100, 1'b1);
    wait_result();
    res_ready_s = 1'b1;
    step(1);
    res_ready_s = 1'b0;
    chk("sat_busy_after_ack", 64'(busy_s), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
